// File: rtl/lna_sched_pkg.sv
// Shared definitions for the LNA scheduler: register map, command entry
// layout, STATUS/CTRL bit positions and FSM state encodings.
package lna_sched_pkg;

  localparam int unsigned LNA_SCHED_ADDR_W = 2;

  typedef enum logic [LNA_SCHED_ADDR_W-1:0] {
    ADDR_CMD    = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_CTRL   = 2'd2,
    ADDR_SETTLE = 2'd3
  } reg_addr_e;

  // Entry fields as they appear in a CMD write word
  localparam int unsigned MODE_LSB  = 0;
  localparam int unsigned MODE_W    = 3;
  localparam int unsigned PD_BIT    = 3;
  localparam int unsigned DWELL_LSB = 8;
  localparam int unsigned DWELL_W   = 24;
  localparam int unsigned ENTRY_W   = DWELL_W + 1 + MODE_W;  // 28

  typedef struct packed {
    logic [DWELL_W-1:0] dwell;
    logic               pd;
    logic [MODE_W-1:0]  mode;
  } entry_t;

  // STATUS read layout
  localparam int unsigned STAT_OVF     = 8;
  localparam int unsigned STAT_FULL    = 7;
  localparam int unsigned STAT_EMPTY   = 6;
  localparam int unsigned STAT_BUSY    = 5;
  localparam int unsigned STAT_LEVEL_W = 5;

  // CTRL write bits
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_FLUSH   = 1;
  localparam int unsigned CTRL_CLR_OVF = 2;

  localparam int unsigned SETTLE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_DWELL  = 2'd3
  } state_e;

  function automatic entry_t cmd_to_entry(input logic [31:0] w);
    entry_t e;
    e.mode  = w[MODE_LSB +: MODE_W];
    e.pd    = w[PD_BIT];
    e.dwell = w[DWELL_LSB +: DWELL_W];
    return e;
  endfunction

endpackage

// File: rtl/lna_sched_fifo.sv
// Synchronous command FIFO for the LNA scheduler.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_wdata   enqueue request and data (accepted when not full, or
//                     when full with a same-cycle pop)
//   i_pop             dequeue request (ignored when empty)
//   i_flush           empties the FIFO; wins over push/pop
//   o_rdata           head entry (combinational from storage)
//   o_level, o_full, o_empty  occupancy
module lna_sched_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 28
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [WIDTH-1:0]        i_wdata,
  output logic [WIDTH-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/lna_sched.sv
// LNA power/gain scheduler: a small native-bus register file feeding a
// command FIFO that an FSM drains, driving pd/mode with optional power-up
// settle time and per-entry dwell.
// Optional feature macro: LNA_SCHED_IRQ_EN adds output irq.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   valid, address, wdata, wstrb   bus request (address: 0 CMD, 1 STATUS,
//                         2 CTRL, 3 SETTLE)
//   rdata, ready          one-cycle completion, read data while ready
//   pd, mode              LNA power-down and gain mode
//   busy                  FSM not IDLE
//   irq (optional)        pulse on drain-to-empty completion or new overflow
module lna_sched
  import lna_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SETTLE_RST = 16,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic [LNA_SCHED_ADDR_W-1:0] address,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        wstrb,
  output logic [DATA_W-1:0]           rdata,
  output logic                        ready,
  output logic                        pd,
  output logic [MODE_W-1:0]           mode,
  output logic                        busy
`ifdef LNA_SCHED_IRQ_EN
  ,
  output logic                        irq
`endif
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                r_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_enable;
  logic                r_ovf;
  logic [SETTLE_W-1:0] r_settle;
  logic                r_pd;
  logic [MODE_W-1:0]   r_mode;
  logic [MODE_W-1:0]   r_pend_mode;
  logic [DWELL_W-1:0]  r_cnt;
  logic [DWELL_W-1:0]  r_dwell_m1;
  state_e              r_state;
  state_e              w_next;

  reg_addr_e           w_addr;
  logic                w_accept;
  logic                w_wr;
  logic                w_ctrl_wr;
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_discard;
  logic [DATA_W-1:0]   w_rd_mux;
  logic [ENTRY_W-1:0]  w_fifo_rdata;
  logic [LVL_W-1:0]    w_level;
  logic                w_full;
  logic                w_empty;
  entry_t              w_entry;
  logic                w_settle_req;
  logic                w_cnt_zero;
  logic [DWELL_W-1:0]  w_dwell_m1;

  // A held valid would otherwise complete twice; accept only when the
  // previous request is not completing this cycle.
  assign w_accept  = valid && !r_ready;
  assign w_addr    = reg_addr_e'(address);
  assign w_wr      = w_accept && wstrb;
  assign w_ctrl_wr = w_wr && (w_addr == ADDR_CTRL);
  assign w_push    = w_wr && (w_addr == ADDR_CMD);
  assign w_flush   = w_ctrl_wr && wdata[CTRL_FLUSH];
  assign w_pop     = (r_state == S_LOAD) && !w_flush;
  assign w_discard = w_push && w_full && !w_pop && !w_flush;

  lna_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (ENTRY_W'(cmd_to_entry(wdata[31:0]))),
    .o_rdata (w_fifo_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_rd_mux = '0;
    case (w_addr)
      ADDR_STATUS: begin
        w_rd_mux[STAT_OVF]              = r_ovf;
        w_rd_mux[STAT_FULL]             = w_full;
        w_rd_mux[STAT_EMPTY]            = w_empty;
        w_rd_mux[STAT_BUSY]             = busy;
        w_rd_mux[STAT_LEVEL_W-1:0]      = STAT_LEVEL_W'(w_level);
      end
      ADDR_CTRL:   w_rd_mux[CTRL_EN]    = r_enable;
      ADDR_SETTLE: w_rd_mux[SETTLE_W-1:0] = r_settle;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_enable <= 1'b0;
      r_ovf    <= 1'b0;
      r_settle <= SETTLE_W'(SETTLE_RST);
    end else begin
      r_ready <= w_accept;
      r_rdata <= (w_accept && !wstrb) ? w_rd_mux : '0;
      if (w_ctrl_wr) r_enable <= wdata[CTRL_EN];
      if (w_wr && (w_addr == ADDR_SETTLE)) r_settle <= wdata[SETTLE_W-1:0];
      if (w_discard) r_ovf <= 1'b1;
      else if (w_ctrl_wr && wdata[CTRL_CLR_OVF]) r_ovf <= 1'b0;
    end
  end

  // ---------------- scheduler FSM ----------------
  assign w_entry      = entry_t'(w_fifo_rdata);
  assign w_settle_req = r_pd && !w_entry.pd && (r_settle != '0);
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_dwell_m1   = (w_entry.dwell == '0) ? '0 : w_entry.dwell - 24'd1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_enable && !w_empty) w_next = S_LOAD;
      S_LOAD:   w_next = w_settle_req ? S_SETTLE : S_DWELL;
      S_SETTLE: if (w_cnt_zero) w_next = S_DWELL;
      S_DWELL:  if (w_cnt_zero) w_next = (r_enable && !w_empty) ? S_LOAD : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_flush) w_next = S_IDLE;
  end

  // Counters hold "cycles remaining minus one", so a phase ends in the
  // cycle where the counter reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pd        <= 1'b1;
      r_mode      <= '0;
      r_pend_mode <= '0;
      r_cnt       <= '0;
      r_dwell_m1  <= '0;
    end else if (w_flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_pd       <= w_entry.pd;
          r_dwell_m1 <= w_dwell_m1;
          if (w_settle_req) begin
            r_pend_mode <= w_entry.mode;
            r_cnt       <= DWELL_W'(r_settle - 16'd1);
          end else begin
            r_mode <= w_entry.mode;
            r_cnt  <= w_dwell_m1;
          end
        end
        S_SETTLE: begin
          if (w_cnt_zero) begin
            r_mode <= r_pend_mode;
            r_cnt  <= r_dwell_m1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DWELL: if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign pd    = r_pd;
  assign mode  = r_mode;
  assign busy  = (r_state != S_IDLE);

`ifdef LNA_SCHED_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= ((r_state == S_DWELL) && w_cnt_zero && !w_flush && w_empty)
                      || (w_discard && !r_ovf);
  end

  assign irq = r_irq;
`endif

endmodule
